// File: rtl/mini_src_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mini_src_datapath
//  Purpose  : 32-bit Mini-SRC CPU datapath. An external sequencer drives
//             every control strobe. Contains 16 GPRs, PC, IR, Y, 64-bit Z,
//             HI, LO, MAR, MDR, In/Out port registers, the CON flip-flop,
//             the shared bus mux, select/encode logic, the ALU and a
//             2**ADDR_W x 32 synchronous RAM.
//  Ports    : clock/clear       - clock, async active-low reset
//             e_* / incPC       - register load strobes (sample the bus)
//             MDR_read          - MDR source: 1 = Mdatain, 0 = bus
//             e_GP/e_Rin/e_RA   - GPR writes (selected reg / R15)
//             e_Rout/BAout      - GPR read onto bus (BAout: R0 reads as 0)
//             Gra/Grb/Grc       - pick IR Ra/Rb/Rc field for select/encode
//             BusDataSelect     - bus source when no GPR read is requested
//             ALU_op/imm_sel    - ALU function, operand B = sign-extended C
//             e_CON_FF          - latch branch condition from IR[20:19]
//             ram_read/ram_write- RAM strobes; Mdatain is the read register
//  Revision : 1.0 - initial release
// ============================================================================
module mini_src_datapath #(
    parameter string MEM_INIT = "ram_init.hex",
    parameter int    ADDR_W   = 9
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        incPC,
    input  logic        e_PC,
    input  logic        e_IR,
    input  logic        e_Y,
    input  logic        e_Z,
    input  logic        e_HI,
    input  logic        e_LO,
    input  logic        e_MAR,
    input  logic        e_InPort,
    input  logic        e_OutPort,
    input  logic        e_MDR,
    input  logic        MDR_read,
    input  logic        e_GP,
    input  logic        e_RA,
    input  logic        e_CON_FF,
    input  logic        ram_read,
    input  logic        ram_write,
    output logic [31:0] Mdatain,
    input  logic [3:0]  ALU_op,
    input  logic [4:0]  BusDataSelect,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        e_Rin,
    input  logic        e_Rout,
    input  logic        BAout,
    input  logic        imm_sel
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [4:0] c_SRC_HI  = 5'd16;
    localparam logic [4:0] c_SRC_LO  = 5'd17;
    localparam logic [4:0] c_SRC_ZHI = 5'd18;
    localparam logic [4:0] c_SRC_ZLO = 5'd19;
    localparam logic [4:0] c_SRC_PC  = 5'd20;
    localparam logic [4:0] c_SRC_MDR = 5'd21;
    localparam logic [4:0] c_SRC_IN  = 5'd22;
    localparam logic [4:0] c_SRC_C   = 5'd23;

    localparam logic [3:0] c_OP_PASS = 4'b0000;
    localparam logic [3:0] c_OP_AND  = 4'b0001;
    localparam logic [3:0] c_OP_OR   = 4'b0010;
    localparam logic [3:0] c_OP_ADD  = 4'b0011;
    localparam logic [3:0] c_OP_SUB  = 4'b0100;
    localparam logic [3:0] c_OP_SHR  = 4'b0101;
    localparam logic [3:0] c_OP_SHRA = 4'b0110;
    localparam logic [3:0] c_OP_SHL  = 4'b0111;
    localparam logic [3:0] c_OP_ROR  = 4'b1000;
    localparam logic [3:0] c_OP_ROL  = 4'b1001;
    localparam logic [3:0] c_OP_MUL  = 4'b1010;
    localparam logic [3:0] c_OP_DIV  = 4'b1011;
    localparam logic [3:0] c_OP_NEG  = 4'b1100;
    localparam logic [3:0] c_OP_NOT  = 4'b1101;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       r_gpr_q [16];
    logic [31:0]       r_pc_q, r_ir_q, r_y_q, r_hi_q, r_lo_q;
    logic [63:0]       r_z_q;
    logic [ADDR_W-1:0] r_mar_q;
    logic [31:0]       r_mdr_q, r_inport_q, r_outport_q, r_mdatain_q;
    logic              r_con_q;
    logic [31:0]       r_mem [c_DEPTH];

    logic [31:0]       w_gpr_d [16];
    logic [31:0]       w_pc_d, w_ir_d, w_y_d, w_hi_d, w_lo_d;
    logic [63:0]       w_z_d;
    logic [ADDR_W-1:0] w_mar_d;
    logic [31:0]       w_mdr_d, w_inport_d, w_outport_d, w_mdatain_d;
    logic              w_con_d;

    logic [3:0]        w_sel;
    logic [31:0]       w_c_sext;
    logic [31:0]       w_bus;
    logic [31:0]       w_alu_a, w_alu_b;
    logic [4:0]        w_amt;
    logic [63:0]       w_prod;
    logic [63:0]       w_alu_res;

    assign Mdatain = r_mdatain_q;

    // Select/encode: the G lines gate IR fields and the results are ORed,
    // so the sequencer normally raises only one of them.
    assign w_sel    = ({4{Gra}} & r_ir_q[26:23]) |
                      ({4{Grb}} & r_ir_q[22:19]) |
                      ({4{Grc}} & r_ir_q[18:15]);
    assign w_c_sext = {{13{r_ir_q[18]}}, r_ir_q[18:0]};

    // ------------------------------------------------------------------
    // Bus mux: a GPR read request overrides BusDataSelect. BAout treats
    // R0 as a hard zero so base-address modes can use R0 as "no base".
    // ------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        if (e_Rout || BAout) begin
            if (BAout && (w_sel == 4'd0)) begin
                w_bus = '0;
            end else begin
                w_bus = r_gpr_q[w_sel];
            end
        end else begin
            case (BusDataSelect)
                c_SRC_HI:  w_bus = r_hi_q;
                c_SRC_LO:  w_bus = r_lo_q;
                c_SRC_ZHI: w_bus = r_z_q[63:32];
                c_SRC_ZLO: w_bus = r_z_q[31:0];
                c_SRC_PC:  w_bus = r_pc_q;
                c_SRC_MDR: w_bus = r_mdr_q;
                c_SRC_IN:  w_bus = r_inport_q;
                c_SRC_C:   w_bus = w_c_sext;
                default:   w_bus = BusDataSelect[4] ? '0 : r_gpr_q[BusDataSelect[3:0]];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU: A is always Y; shifts and rotates act on A by B[4:0].
    // ------------------------------------------------------------------
    assign w_alu_a = r_y_q;
    assign w_alu_b = imm_sel ? w_c_sext : w_bus;
    assign w_amt   = w_alu_b[4:0];
    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_prod  = {{32{w_alu_a[31]}}, w_alu_a} * {{32{w_alu_b[31]}}, w_alu_b};

    always_comb begin
        w_alu_res = '0;
        case (ALU_op)
            c_OP_PASS: w_alu_res[31:0] = w_alu_b;
            c_OP_AND:  w_alu_res[31:0] = w_alu_a & w_alu_b;
            c_OP_OR:   w_alu_res[31:0] = w_alu_a | w_alu_b;
            c_OP_ADD:  w_alu_res[31:0] = w_alu_a + w_alu_b;
            c_OP_SUB:  w_alu_res[31:0] = w_alu_a - w_alu_b;
            c_OP_SHR:  w_alu_res[31:0] = w_alu_a >> w_amt;
            c_OP_SHRA: w_alu_res[31:0] = $signed(w_alu_a) >>> w_amt;
            c_OP_SHL:  w_alu_res[31:0] = w_alu_a << w_amt;
            // A shift by 32 yields 0, so amount 0 degenerates cleanly.
            c_OP_ROR:  w_alu_res[31:0] = (w_alu_a >> w_amt) |
                                         (w_alu_a << (6'd32 - {1'b0, w_amt}));
            c_OP_ROL:  w_alu_res[31:0] = (w_alu_a << w_amt) |
                                         (w_alu_a >> (6'd32 - {1'b0, w_amt}));
            c_OP_MUL:  w_alu_res = w_prod;
            c_OP_DIV: begin
                if (w_alu_b != 32'd0) begin
                    w_alu_res[31:0]  = $signed(w_alu_a) / $signed(w_alu_b);
                    w_alu_res[63:32] = $signed(w_alu_a) % $signed(w_alu_b);
                end
            end
            c_OP_NEG:  w_alu_res[31:0] = 32'd0 - w_alu_b;
            c_OP_NOT:  w_alu_res[31:0] = ~w_alu_b;
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_gpr_d     = r_gpr_q;
        w_pc_d      = r_pc_q;
        w_ir_d      = r_ir_q;
        w_y_d       = r_y_q;
        w_z_d       = r_z_q;
        w_hi_d      = r_hi_q;
        w_lo_d      = r_lo_q;
        w_mar_d     = r_mar_q;
        w_mdr_d     = r_mdr_q;
        w_inport_d  = r_inport_q;
        w_outport_d = r_outport_q;
        w_con_d     = r_con_q;
        w_mdatain_d = r_mdatain_q;

        if (e_Rin || e_GP) w_gpr_d[w_sel] = w_bus;
        if (e_RA)          w_gpr_d[15]    = w_bus;

        if (e_PC) begin
            w_pc_d = w_bus;
        end else if (incPC) begin
            w_pc_d = r_pc_q + 32'd1;
        end

        if (e_IR)      w_ir_d      = w_bus;
        if (e_Y)       w_y_d       = w_bus;
        if (e_Z)       w_z_d       = w_alu_res;
        if (e_HI)      w_hi_d      = w_bus;
        if (e_LO)      w_lo_d      = w_bus;
        if (e_MAR)     w_mar_d     = w_bus[ADDR_W-1:0];
        if (e_InPort)  w_inport_d  = w_bus;
        if (e_OutPort) w_outport_d = w_bus;
        if (e_MDR)     w_mdr_d     = MDR_read ? r_mdatain_q : w_bus;
        if (ram_read)  w_mdatain_d = r_mem[r_mar_q];

        if (e_CON_FF) begin
            case (r_ir_q[20:19])
                2'b00:   w_con_d = (w_bus == 32'd0);
                2'b01:   w_con_d = (w_bus != 32'd0);
                2'b10:   w_con_d = ~w_bus[31];
                default: w_con_d = w_bus[31];
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_gpr_q[i] <= '0;
            r_pc_q      <= '0;
            r_ir_q      <= '0;
            r_y_q       <= '0;
            r_z_q       <= '0;
            r_hi_q      <= '0;
            r_lo_q      <= '0;
            r_mar_q     <= '0;
            r_mdr_q     <= '0;
            r_inport_q  <= '0;
            r_outport_q <= '0;
            r_con_q     <= 1'b0;
            r_mdatain_q <= '0;
        end else begin
            r_gpr_q     <= w_gpr_d;
            r_pc_q      <= w_pc_d;
            r_ir_q      <= w_ir_d;
            r_y_q       <= w_y_d;
            r_z_q       <= w_z_d;
            r_hi_q      <= w_hi_d;
            r_lo_q      <= w_lo_d;
            r_mar_q     <= w_mar_d;
            r_mdr_q     <= w_mdr_d;
            r_inport_q  <= w_inport_d;
            r_outport_q <= w_outport_d;
            r_con_q     <= w_con_d;
            r_mdatain_q <= w_mdatain_d;
        end
    end

    // RAM array is not reset; its contents survive clear. A same-edge
    // read sees the pre-write word because both use non-blocking updates.
    always_ff @(posedge clock) begin
        if (ram_write) r_mem[r_mar_q] <= r_mdr_q;
    end

    // Opcode, OutPort and CON have no consumer inside this block.
    logic w_unused;
    assign w_unused = ^{r_ir_q[31:27], r_outport_q, r_con_q};

endmodule
`default_nettype wire

// File: tb/tb_mini_src_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini_src_datapath
//  Purpose  : Self-checking bench for mini_src_datapath. Drives control
//             sequences, queues expected register values, compares after
//             each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mini_src_datapath;

    logic        clock, clear, incPC;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_InPort, e_OutPort;
    logic        e_MDR, MDR_read, e_GP, e_RA, e_CON_FF, ram_read, ram_write;
    logic [31:0] Mdatain;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;

    mini_src_datapath #(.MEM_INIT(""), .ADDR_W(9)) dut (
        .clock(clock), .clear(clear), .incPC(incPC),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
        .e_MAR(e_MAR), .e_InPort(e_InPort), .e_OutPort(e_OutPort),
        .e_MDR(e_MDR), .MDR_read(MDR_read), .e_GP(e_GP), .e_RA(e_RA),
        .e_CON_FF(e_CON_FF), .ram_read(ram_read), .ram_write(ram_write),
        .Mdatain(Mdatain), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout),
        .BAout(BAout), .imm_sel(imm_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam int K_PC = 0, K_IR = 1, K_Y = 2, K_Z = 3, K_MAR = 4;
    localparam int K_MDR = 5, K_CON = 6, K_MDATA = 7, K_GPR = 16;

    localparam logic [4:0] S_ZLO = 5'd19, S_PC = 5'd20, S_MDR = 5'd21;
    localparam logic [4:0] S_C = 5'd23, S_ZERO = 5'd24, S_HI = 5'd16;

    int n_checks = 0;
    int n_fails  = 0;

    string       sb_tag  [$];
    int          sb_kind [$];
    logic [63:0] sb_exp  [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_PC:    return {32'h0, dut.r_pc_q};
            K_IR:    return {32'h0, dut.r_ir_q};
            K_Y:     return {32'h0, dut.r_y_q};
            K_Z:     return dut.r_z_q;
            K_MAR:   return {55'h0, dut.r_mar_q};
            K_MDR:   return {32'h0, dut.r_mdr_q};
            K_CON:   return {63'h0, dut.r_con_q};
            K_MDATA: return {32'h0, Mdatain};
            default: return {32'h0, dut.r_gpr_q[4'(kind - K_GPR)]};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input logic [63:0] v);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_exp.push_back(v);
    endtask

    task automatic drain();
        while (sb_kind.size() > 0) begin
            string t;
            int    k;
            logic [63:0] e;
            t = sb_tag.pop_front();
            k = sb_kind.pop_front();
            e = sb_exp.pop_front();
            check(t, observe(k), e);
        end
    endtask

    task automatic ctl_idle();
        incPC = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_Z = 0; e_HI = 0; e_LO = 0;
        e_MAR = 0; e_InPort = 0; e_OutPort = 0; e_MDR = 0; MDR_read = 0;
        e_GP = 0; e_RA = 0; e_CON_FF = 0; ram_read = 0; ram_write = 0;
        ALU_op = 4'd0; BusDataSelect = 5'd24; Gra = 0; Grb = 0; Grc = 0;
        e_Rin = 0; e_Rout = 0; BAout = 0; imm_sel = 0;
    endtask

    // One clock edge: outputs settle, queued expectations are compared,
    // then all strobes drop.
    task automatic tick();
        @(posedge clock);
        #1;
        drain();
        ctl_idle();
    endtask

    task automatic fetch(input logic [63:0] pc_next, input logic [63:0] ir_exp);
        BusDataSelect = S_PC; e_MAR = 1; incPC = 1;
        expect_val("fetch_pc", K_PC, pc_next);
        tick();
        ram_read = 1; tick();
        MDR_read = 1; e_MDR = 1; tick();
        BusDataSelect = S_MDR; e_IR = 1;
        expect_val("fetch_ir", K_IR, ir_exp);
        tick();
    endtask

    // Ra <= R[Rb]/0 + C with Rb read through BAout (Rb=0 gives 0).
    task automatic ldi(input int ra, input logic [63:0] v);
        Grb = 1; BAout = 1; e_Y = 1; tick();
        imm_sel = 1; ALU_op = 4'b0011; e_Z = 1; tick();
        BusDataSelect = S_ZLO; Gra = 1; e_Rin = 1;
        expect_val("ldi_rd", K_GPR + ra, v);
        tick();
    endtask

    // Y=7 (R4), B from bus source table
    logic [3:0]  ops_a [0:8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15, 4'd10, 4'd11, 4'd11};
    logic [4:0]  src_a [0:8] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd24};
    logic [63:0] exp_a [0:8] = '{64'h0000_0000_FFFF_FFFD, 64'h5, 64'h0000_0000_FFFF_FFFF,
                                 64'h4, 64'hA, 64'h0, 64'hFFFF_FFFF_FFFF_FFEB,
                                 64'h0000_0001_FFFF_FFFE, 64'h0};
    // Y=0xFFFFFFFD (R3), B = immediate C = 7
    logic [3:0]  ops_b [0:6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd13};
    logic [63:0] exp_b [0:6] = '{64'h01FF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FE80,
                                 64'hFBFF_FFFF, 64'hFFFF_FEFF, 64'hFFFF_FFF9,
                                 64'hFFFF_FFF8};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0;
        ctl_idle();
        dut.r_mem[0]    = 32'h4100_0078;   // ldi R2,0x78
        dut.r_mem[1]    = 32'h4310_0063;   // ld  R6,0x63(R2)
        dut.r_mem[2]    = 32'h0187_FFFD;   // Ra=3, C=-3
        dut.r_mem[3]    = 32'h0200_0007;   // Ra=4, C=7
        dut.r_mem[4]    = 32'h0288_CAFE;   // Ra=5, Rb=1 (IR[20:19]=01), C=0xCAFE
        dut.r_mem[5]    = 32'h1111_1111;
        dut.r_mem[9'hDB] = 32'h0000_0046;

        #12;
        expect_val("rst_pc", K_PC, 64'h0);
        expect_val("rst_z", K_Z, 64'h0);
        expect_val("rst_mdatain", K_MDATA, 64'h0);
        drain();
        @(negedge clock);
        clear = 1'b1;

        // Fetch ldi R2,0x78 and execute
        fetch(64'h1, 64'h4100_0078);
        expect_val("fetch_mar", K_MAR, 64'h0);
        drain();
        ldi(2, 64'h78);

        // ld R6,0x63(R2)
        fetch(64'h2, 64'h4310_0063);
        Grb = 1; e_Rout = 1; e_Y = 1;
        expect_val("ld_y", K_Y, 64'h78); tick();
        imm_sel = 1; ALU_op = 4'b0011; e_Z = 1;
        expect_val("ld_ea", K_Z, 64'hDB); tick();
        BusDataSelect = S_ZLO; e_MAR = 1;
        expect_val("ld_mar", K_MAR, 64'hDB); tick();
        ram_read = 1;
        expect_val("ld_mdatain", K_MDATA, 64'h46); tick();
        MDR_read = 1; e_MDR = 1; tick();
        BusDataSelect = S_MDR; Gra = 1; e_Rin = 1;
        expect_val("ld_r6", K_GPR + 6, 64'h46); tick();

        fetch(64'h3, 64'h0187_FFFD);
        ldi(3, 64'hFFFF_FFFD);
        fetch(64'h4, 64'h0200_0007);
        ldi(4, 64'h7);

        // ALU with Y=7 and bus operand
        BusDataSelect = 5'd4; e_Y = 1; tick();
        for (int i = 0; i < 9; i++) begin
            BusDataSelect = src_a[i]; ALU_op = ops_a[i]; e_Z = 1;
            expect_val($sformatf("alu_a%0d", i), K_Z, exp_a[i]);
            tick();
        end

        // Shifts/rotates/unary with Y=-3 and immediate B=7
        BusDataSelect = 5'd3; e_Y = 1; tick();
        for (int i = 0; i < 7; i++) begin
            imm_sel = 1; ALU_op = ops_b[i]; e_Z = 1;
            expect_val($sformatf("alu_b%0d", i), K_Z, exp_b[i]);
            tick();
        end

        // Store path and same-edge read/write ordering
        fetch(64'h5, 64'h0288_CAFE);
        BusDataSelect = S_C; e_MDR = 1;
        expect_val("st_mdr", K_MDR, 64'hCAFE); tick();
        BusDataSelect = S_PC; e_MAR = 1;
        expect_val("st_mar", K_MAR, 64'h5); tick();
        ram_read = 1; ram_write = 1;
        expect_val("rw_old", K_MDATA, 64'h1111_1111); tick();
        ram_read = 1;
        expect_val("rd_new", K_MDATA, 64'hCAFE); tick();

        // CON_FF, condition 01 (bus != 0)
        BusDataSelect = 5'd4; e_CON_FF = 1;
        expect_val("con_nz", K_CON, 64'h1); tick();
        BusDataSelect = S_ZERO; e_CON_FF = 1;
        expect_val("con_z", K_CON, 64'h0); tick();

        // PC: load beats increment, then increment, then hold
        BusDataSelect = 5'd2; e_PC = 1; incPC = 1;
        expect_val("pc_load", K_PC, 64'h78); tick();
        incPC = 1;
        expect_val("pc_inc", K_PC, 64'h79); tick();
        expect_val("pc_hold", K_PC, 64'h79); tick();

        // R0 writable; BAout forces 0 while e_Rout reads it
        BusDataSelect = S_PC; e_Rin = 1;
        expect_val("r0_wr", K_GPR + 0, 64'h79); tick();
        BAout = 1; e_Y = 1;
        expect_val("baout_r0", K_Y, 64'h0); tick();
        e_Rout = 1; e_Y = 1;
        expect_val("rout_r0", K_Y, 64'h79); tick();

        // HI path, e_RA, R5 and Z loaded before reset
        BusDataSelect = 5'd4; e_HI = 1; tick();
        BusDataSelect = S_HI; e_Y = 1;
        expect_val("hi_y", K_Y, 64'h7); tick();
        BusDataSelect = 5'd4; e_RA = 1;
        expect_val("ra_r15", K_GPR + 15, 64'h7); tick();
        BusDataSelect = S_PC; Gra = 1; e_Rin = 1;
        expect_val("r5_wr", K_GPR + 5, 64'h79); tick();
        BusDataSelect = S_PC; ALU_op = 4'd0; e_Z = 1;
        expect_val("z_pass", K_Z, 64'h79); tick();

        // Asynchronous clear mid-cycle
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        expect_val("aclr_pc", K_PC, 64'h0);
        expect_val("aclr_r5", K_GPR + 5, 64'h0);
        expect_val("aclr_z", K_Z, 64'h0);
        expect_val("aclr_ir", K_IR, 64'h0);
        expect_val("aclr_mdatain", K_MDATA, 64'h0);
        drain();
        @(negedge clock);
        clear = 1'b1;

        // RAM retained through clear; MAR is 0 again
        ram_read = 1;
        expect_val("ram_keep", K_MDATA, 64'h4100_0078); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
